led_fade_sequencer: RTL
=======================

Name: led_fade_sequencer

Overview:
Upstream stage for the PWM LED driver. It generates a triangular brightness profile: rise, hold high, fall, hold low, repeat. It emits an optionally gamma-corrected duty value.
Duty updates are committed only on the PWM stage's period-wrap pulse, so the downstream comparator never sees a mid-period change. The block replaces the ad-hoc fade counter inside the PWM stage; that stage becomes a pure duty-to-pulse converter.

Parameters:
DUTY_W, 8, width of level and duty; DUTY_MAX = 2**DUTY_W-1
STEP_DIV, 10000, clocks per brightness step (>=2)
HOLD_STEPS, 0, steps spent in each hold state; 0 skips the holds
GAMMA_EN, 1, 1 = square-law duty, 0 = linear duty

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
enable  in  1  run the fade sequence; low forces fade-out to 0 immediately
pwm_wrap  in  1  one-cycle pulse from the PWM stage at counter wrap (period boundary)
duty  out  DUTY_W  committed duty value for the PWM comparator
duty_valid  out  1  one-cycle pulse in the cycle after duty changes value
fading_up  out  1  1 in IDLE/RISE/HOLD_LO, 0 in HOLD_HI/FALL
at_peak  out  1  1 while in HOLD_HI, or for the step at DUTY_MAX when HOLD_STEPS=0

Behaviour:
- Reset values: duty=0, duty_valid=0, fading_up=1, at_peak=0, state=IDLE, level=0, prescaler=0, hold_cnt=0, pending=0.
- Prescaler: counts 0..STEP_DIV-1 while state!=IDLE. tick=1 in the cycle it equals STEP_DIV-1, then it wraps to 0. It is cleared on entry to IDLE.
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO.
- IDLE: level=0. When enable=1, go to RISE on the next cycle.
- RISE: on tick, level+1. On the tick that makes level=DUTY_MAX, go to HOLD_HI, or to FALL if HOLD_STEPS=0.
- HOLD_HI: hold_cnt counts ticks. After HOLD_STEPS ticks, go to FALL with hold_cnt=0.
- FALL: on tick, level-1. On the tick that makes level=0, go to HOLD_LO, or to RISE if HOLD_STEPS=0.
- HOLD_LO: mirror of HOLD_HI, then go to RISE.
- Level saturates at 0 and DUTY_MAX; no wrap-around under any state.
- enable=0 in any state: next cycle state=IDLE, level=0, prescaler=0. duty follows to 0 at the next pwm_wrap through the normal commit path.
- Gamma: pending is registered one cycle after level.
  - GAMMA_EN=1: pending = (level*level)>>DUTY_W, using a 2*DUTY_W-bit product. DUTY_MAX maps to DUTY_MAX-1, and 0 maps to 0.
  - GAMMA_EN=0: pending = level.
- Commit: in a cycle with pwm_wrap=1, duty <= pending (value registered before this edge).
  - duty_valid=1 in the following cycle iff the committed value differs from the prior duty.
  - With no pwm_wrap, duty holds indefinitely.
- Latency: tick edge -> level (+1 clk) -> pending (+1 clk) -> duty at the first pwm_wrap at or after that cycle.
- Simultaneous tick and pwm_wrap: the wrap commits the pre-tick pending value; the new level commits at the next wrap.
- Simultaneous enable fall and pwm_wrap: the wrap commits the current pending value; 0 commits at the following wrap.
- rst mid-sequence: all registers return to reset values on that edge, and duty=0 immediately, without waiting for pwm_wrap.

Decomposition:
- Shared package led_pkg:
  - fade_state_t enum (IDLE, RISE, HOLD_HI, FALL, HOLD_LO)
  - function duty_max(width)
  - default STEP_DIV constant, also used by the PWM stage
- One sub-module, fade_gamma: registered level-to-duty mapping with the GAMMA_EN parameter, 1-cycle latency, sync reset to 0.
- FSM, prescaler and commit logic stay in the top.

Test Plan:
- Reset/idle: DUTY_W=4, STEP_DIV=4, HOLD_STEPS=2, GAMMA_EN=0, enable=0, pwm_wrap every 16 clk -> duty=0, duty_valid never asserts, fading_up=1, at_peak=0.
- Full linear cycle: same config with enable=1 -> level 0..15 in 15 ticks (60 clk).
  - at_peak=1 for exactly 8 clk.
  - Then 15..0 with fading_up=0, then HOLD_LO for 8 clk.
  - Committed duty sequence equals the sampled level per wrap; never exceeds 15 or underflows.
- Gamma: GAMMA_EN=1, DUTY_W=8, pwm_wrap every cycle -> duty 0 for level 0..15, 64 at level 128, 254 at level 255.
- Wrap gating: hold pwm_wrap=0 for 200 clk while enabled -> duty constant. A single pwm_wrap then commits the latest pending value, and duty_valid pulses once.
- Coincidence: force tick and pwm_wrap in the same cycle at level 5->6 (linear) -> duty=5 after that wrap and 6 after the next wrap.
- Disable/reset: drop enable at level 9 in RISE -> IDLE next cycle, duty=0 at the next wrap. Separately, assert rst at level 12 -> duty=0 on the same edge, and all outputs are at reset values.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pkg                                                                     |
// | Shared types and constants for the LED fade sequencer and the PWM stage.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } fade_state_t;

  localparam int STEP_DIV_DEFAULT = 10000;

  function automatic int duty_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fade_gamma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fade_gamma                                                                  |
// | Registered level-to-duty mapping: square-law or linear, 1-cycle latency.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fade_gamma #(
  parameter int DUTY_W   = 8,
  parameter int GAMMA_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] i_level,
  output logic [DUTY_W-1:0] o_pending
);

  logic [DUTY_W-1:0] w_mapped;
  logic [DUTY_W-1:0] r_pending;

  generate
    if (GAMMA_EN != 0) begin : g_square
      logic [2*DUTY_W-1:0] w_product;
      assign w_product = {{DUTY_W{1'b0}}, i_level} * {{DUTY_W{1'b0}}, i_level};
      assign w_mapped  = DUTY_W'(w_product >> DUTY_W);
    end else begin : g_linear
      assign w_mapped = i_level;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_mapped;
    end
  end

  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/led_fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_fade_sequencer                                                          |
// | Triangular brightness sequencer; duty commits only on the PWM period wrap. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module led_fade_sequencer
  import led_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int STEP_DIV   = STEP_DIV_DEFAULT,
  parameter int HOLD_STEPS = 0,
  parameter int GAMMA_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_wrap,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              fading_up,
  output logic              at_peak
);

  localparam logic [DUTY_W-1:0] c_duty_max = DUTY_W'(duty_max(DUTY_W));
  localparam int                c_presc_w  = $clog2(STEP_DIV);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(STEP_DIV - 1);
  localparam int                c_hold_w   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);

  localparam logic [2:0] c_st_idle    = IDLE;
  localparam logic [2:0] c_st_rise    = RISE;
  localparam logic [2:0] c_st_hold_hi = HOLD_HI;
  localparam logic [2:0] c_st_fall    = FALL;
  localparam logic [2:0] c_st_hold_lo = HOLD_LO;

  logic [2:0]           r_state;
  logic [DUTY_W-1:0]    r_level;
  logic [c_presc_w-1:0] r_presc;
  logic [c_hold_w-1:0]  r_hold;
  logic [DUTY_W-1:0]    r_duty;
  logic                 r_duty_valid;
  logic [DUTY_W-1:0]    w_pending;
  logic                 w_tick;

  assign w_tick = (r_state != c_st_idle) && (r_presc == c_presc_last);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state <= c_st_idle;
      r_level <= '0;
      r_presc <= '0;
      r_hold  <= '0;
    end else begin
      if (r_state != c_st_idle) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      case (r_state)
        c_st_idle: r_state <= c_st_rise;
        c_st_rise: begin
          if (w_tick && (r_level != c_duty_max)) begin
            r_level <= r_level + 1'b1;
            if (r_level == c_duty_max - 1'b1) begin
              r_state <= (HOLD_STEPS == 0) ? c_st_fall : c_st_hold_hi;
            end
          end
        end
        c_st_hold_hi: begin
          if (w_tick) begin
            if (r_hold == c_hold_last) begin
              r_hold  <= '0;
              r_state <= c_st_fall;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        c_st_fall: begin
          if (w_tick && (r_level != '0)) begin
            r_level <= r_level - 1'b1;
            if (r_level == {{(DUTY_W-1){1'b0}}, 1'b1}) begin
              r_state <= (HOLD_STEPS == 0) ? c_st_rise : c_st_hold_lo;
            end
          end
        end
        c_st_hold_lo: begin
          if (w_tick) begin
            if (r_hold == c_hold_last) begin
              r_hold  <= '0;
              r_state <= c_st_rise;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  fade_gamma #(
    .DUTY_W   (DUTY_W),
    .GAMMA_EN (GAMMA_EN)
  ) u_gamma (
    .clk       (clk),
    .rst       (rst),
    .i_level   (r_level),
    .o_pending (w_pending)
  );

  // Commit only at the period boundary so the comparator never sees a mid-period change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= pwm_wrap && (w_pending != r_duty);
      if (pwm_wrap) begin
        r_duty <= w_pending;
      end
    end
  end

  assign duty       = r_duty;
  assign duty_valid = r_duty_valid;
  assign fading_up  = (r_state == c_st_idle) || (r_state == c_st_rise) || (r_state == c_st_hold_lo);
  assign at_peak    = (r_state == c_st_hold_hi) ||
                      ((HOLD_STEPS == 0) && (r_state == c_st_fall) && (r_level == c_duty_max));

endmodule
`default_nettype wire
